spi_cmd_master: RTL
===================

# spi_cmd_master

Command-level SPI master that drives the single-clock SS_n/MOSI/MISO link of the SPI slave wrapper and its RAM. It serializes one 10-bit command word per frame: 2-bit opcode plus 8-bit payload. Opcode 11 (read data) keeps the frame open and captures the slave's 8-bit reply from MISO. It sits between a host-side command source (CPU bridge or test sequencer) and the SPI_Wrapper pins.

## Interface
Parameters:
- PRE_CYCLES, 2: cycles with SS_n low before the first command bit (legal 1..15).
- RD_WAIT, 2: dead cycles between the last command bit and the first MISO sample, opcode 11 only (legal 0..15).
- GAP_CYCLES, 2: cycles SS_n is held high after each frame before the next command may be accepted (legal 1..15).

Ports:
- clk  in  1  system clock; all SPI signals are synchronous to it.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command word available.
- cmd_ready  out  1  master can accept a command (high only in IDLE).
- cmd_data  in  10  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- rd_data  out  8  byte captured in the last opcode-11 frame; holds until the next one.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- busy  out  1  high whenever the state is not IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.

## Operation
- States: IDLE, START, SHIFT, WAIT_RD, RECV, GAP.
- IDLE: SS_n=1, MOSI=0, cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_data into a 10-bit shift register, then go to START.
- START: SS_n=0 and MOSI=cmd[9] (the slave's command-select bit) for PRE_CYCLES cycles, then go to SHIFT.
- SHIFT: 10 cycles with MOSI=cmd[9], cmd[8] ... cmd[0], MSB first, one bit per clk.
  - Opcode≠11: go to GAP.
  - Opcode=11: go to WAIT_RD.
- WAIT_RD: SS_n=0, MOSI=0 for RD_WAIT cycles; RD_WAIT=0 skips the state. Then go to RECV.
- RECV: SS_n=0, MOSI=0 for 8 cycles. MISO is sampled at the rising edge ending each cycle and shifted in MSB first. After the 8th sample, go to GAP.
- GAP: SS_n=1, MOSI=0 for GAP_CYCLES cycles, then go to IDLE.
  - On entry from RECV, rd_data loads the assembled byte and rd_valid=1 for that first GAP cycle only.
- Counters: one 4-bit down-counter shared by START/SHIFT/WAIT_RD/RECV/GAP, reloaded on each state entry.
- cmd_data is sampled only at acceptance; later changes are ignored. cmd_valid outside IDLE is not accepted and not queued.
- No opcode checking: all four opcodes are legal, and only opcode 11 triggers a receive phase.

## Timing
- Reset values: SS_n=1, MOSI=0, cmd_ready=1, busy=0, rd_valid=0, rd_data=8'h00, state=IDLE, counters=0.
- rst is sampled every edge with priority over everything. Reset mid-frame forces SS_n=1 and MOSI=0 at the same edge, aborts the frame, leaves rd_data unchanged (except the reset value), and produces no rd_valid.
- All outputs are registered except cmd_ready/busy, which decode the registered state.
- Acceptance edge = cycle 0. SS_n falls at edge 1. First payload bit cmd[9] is driven at cycle 1+PRE_CYCLES.
- SS_n low time:
  - Opcodes 00/01/10: PRE_CYCLES+10 cycles (12 with defaults).
  - Opcode 11: PRE_CYCLES+10+RD_WAIT+8 cycles (22 with defaults).
- rd_valid asserts on the same cycle SS_n returns high.
- Back-to-back commands: cmd_ready re-asserts GAP_CYCLES cycles after SS_n rises. Minimum accept-to-accept period is 1+PRE_CYCLES+10+GAP_CYCLES (15 default) for non-read frames.
- MOSI changes only on clk rising edges, so the slave sees each bit stable for a full cycle.

## Test plan
- Reset: hold rst 3 cycles mid-opcode-11 frame → SS_n=1 and MOSI=0 the following cycle, rd_valid never pulses, cmd_ready=1 after rst drops.
- Write-address 10'b00_00000001 → SS_n low exactly 12 cycles; MOSI stream = 0,0 then 0000000001; then SS_n high 2 cycles before cmd_ready=1.
- Write-data 10'b01_10101011 → MOSI stream = 0,0,0110101011; checked with a bit-level monitor against the expected pattern.
- Full RAM round trip against SPI_Wrapper:
  - Issue 00_01, 01_AB, 10_01, then 11_00.
  - Required: rd_valid pulses once, rd_data=8'hAB, SS_n low 22 cycles in the read frame.
- Back-to-back: cmd_valid held high with 4 queued commands → accepts spaced exactly 15 cycles; no command dropped or duplicated; cmd_data changes during a frame do not affect MOSI.
- Parameter corners, PRE_CYCLES=1, RD_WAIT=0, GAP_CYCLES=1, slave model returning 8'h5A → first MISO sample taken the cycle after cmd[0]; rd_data=8'h5A.

Source files
------------

// File: rtl/spi_cmd_master.sv
// Command-level SPI master: serializes a 10-bit opcode+payload word per SS_n frame
// and, for opcode 11, captures the slave's 8-bit reply from MISO.
module spi_cmd_master #(
    parameter int unsigned PRE_CYCLES = 2,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_WAIT_RD = 3'd3,
        ST_RECV    = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    localparam logic [3:0] PRE_LD   = 4'(PRE_CYCLES);
    localparam logic [3:0] RDW_LD   = 4'(RD_WAIT);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYCLES);
    localparam logic [3:0] SHIFT_LD = 4'd10;
    localparam logic [3:0] RECV_LD  = 4'd8;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [9:0]  cmd_q;
    logic        is_rd_q;
    logic [7:0]  rx_q;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q;
    logic        ss_n_q;
    logic        mosi_q;
    logic        rx_en_q;
    logic        rx_last_q;
    logic        last_s;

    assign last_s    = (cnt_q == 4'd1);
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

    // Frame sequencer; pin outputs are registered from the state held before each edge,
    // so the pins trail the state by one cycle and MISO capture is delayed to match.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            cmd_q      <= 10'd0;
            is_rd_q    <= 1'b0;
            rx_q       <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_en_q    <= 1'b0;
            rx_last_q  <= 1'b0;
        end else begin
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_en_q    <= 1'b0;
            rx_last_q  <= 1'b0;
            rd_valid_q <= rx_last_q;
            if (rx_en_q) begin
                rx_q <= {rx_q[6:0], MISO};
            end else begin
                rx_q <= rx_q;
            end
            // The final sample goes straight into rd_data so it lands as SS_n rises.
            if (rx_last_q) begin
                rd_data_q <= {rx_q[6:0], MISO};
            end else begin
                rd_data_q <= rd_data_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q   <= cmd_data;
                        is_rd_q <= (cmd_data[9:8] == 2'b11);
                        cnt_q   <= PRE_LD;
                        state_q <= ST_START;
                    end else begin
                        cnt_q   <= 4'd0;
                    end
                end
                ST_START: begin
                    ss_n_q <= 1'b0;
                    mosi_q <= cmd_q[9];
                    if (last_s) begin
                        cnt_q   <= SHIFT_LD;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                ST_SHIFT: begin
                    ss_n_q <= 1'b0;
                    mosi_q <= cmd_q[9];
                    cmd_q  <= {cmd_q[8:0], 1'b0};
                    if (last_s) begin
                        if (!is_rd_q) begin
                            cnt_q   <= GAP_LD;
                            state_q <= ST_GAP;
                        end else if (RD_WAIT == 0) begin
                            cnt_q   <= RECV_LD;
                            state_q <= ST_RECV;
                        end else begin
                            cnt_q   <= RDW_LD;
                            state_q <= ST_WAIT_RD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_WAIT_RD: begin
                    ss_n_q <= 1'b0;
                    if (last_s) begin
                        cnt_q   <= RECV_LD;
                        state_q <= ST_RECV;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                ST_RECV: begin
                    ss_n_q    <= 1'b0;
                    rx_en_q   <= 1'b1;
                    rx_last_q <= last_s;
                    if (last_s) begin
                        cnt_q   <= GAP_LD;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                ST_GAP: begin
                    if (last_s) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    cnt_q   <= 4'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
